// File: rtl/keypad_if.sv
// Operand handshake between the keypad scanner (producer) and the CPU I/O path.
interface keypad_if;
  logic [31:0] value;
  logic [3:0]  digit_cnt;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        valid;
  logic        ack;

  modport master (output value, digit_cnt, key_code, key_valid, valid, input ack);
  modport slave  (input value, digit_cnt, key_code, key_valid, valid, output ack);
endinterface

// File: rtl/keypad_input.sv
// 4x4 hex keypad scanner with per-key debounce, building a 32-bit operand
// that is committed to the consumer through a valid/ack handshake.
module keypad_input #(
  parameter int SCAN_CYCLES = 23000,
  parameter int DB_COUNT    = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  input  logic       btn_enter,
  input  logic       btn_clear,
  keypad_if.master   bus
);
  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DB_COUNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [1:0]    btn_s1_q, btn_s2_q, btn_prev_q;  // {clear, enter}
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    cand_col_q, cand_col_d;
  logic [DW-1:0] db_q, db_d;
  logic [31:0]   value_q, value_d;
  logic [3:0]    digit_cnt_q, digit_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          valid_q, valid_d;

  logic          tick, any_low, accept, ent_edge, clr_edge, db_last;
  logic [1:0]    low_idx;
  logic [3:0]    code;

  assign tick     = (cnt_q == CW'(SCAN_CYCLES - 1));
  assign any_low  = ~&col_s2_q;
  assign db_last  = (db_q == DW'(DB_COUNT - 1));
  assign ent_edge = btn_s2_q[0] & ~btn_prev_q[0];
  assign clr_edge = btn_s2_q[1] & ~btn_prev_q[1];
  assign code     = {row_idx_q, cand_col_q};

  always_comb begin
    if      (!col_s2_q[0]) low_idx = 2'd0;
    else if (!col_s2_q[1]) low_idx = 2'd1;
    else if (!col_s2_q[2]) low_idx = 2'd2;
    else                   low_idx = 2'd3;
  end

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    cand_col_d  = cand_col_q;
    db_d        = db_q;
    accept      = 1'b0;
    value_d     = value_q;
    digit_cnt_d = digit_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    valid_d     = valid_q;

    if (tick) begin
      case (state_q)
        SCAN:
          if (any_low) begin
            state_d    = DEBOUNCE;
            cand_col_d = low_idx;
            db_d       = '0;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        DEBOUNCE:
          if (any_low && low_idx == cand_col_q) begin
            if (db_last) begin
              accept  = 1'b1;
              state_d = RELEASE;
              db_d    = '0;
            end else begin
              db_d = db_q + DW'(1);
            end
          end else begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        RELEASE:
          if (!any_low) begin
            if (db_last) begin
              state_d   = SCAN;
              row_idx_d = row_idx_q + 2'd1;
              db_d      = '0;
            end else begin
              db_d = db_q + DW'(1);
            end
          end else begin
            db_d = '0;
          end
        default: state_d = SCAN;
      endcase
    end

    // While committed only ack matters; otherwise clear > enter > key accept.
    if (valid_q) begin
      if (bus.ack) begin
        valid_d     = 1'b0;
        value_d     = '0;
        digit_cnt_d = '0;
      end
    end else if (clr_edge) begin
      value_d     = '0;
      digit_cnt_d = '0;
    end else if (ent_edge && digit_cnt_q != 4'd0) begin
      valid_d = 1'b1;
    end else if (accept && digit_cnt_q < 4'd8) begin
      value_d     = {value_q[27:0], code};
      digit_cnt_d = digit_cnt_q + 4'd1;
      key_code_d  = code;
      key_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      btn_s1_q    <= 2'b11;
      btn_s2_q    <= 2'b11;
      btn_prev_q  <= 2'b11;
      cnt_q       <= '0;
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      cand_col_q  <= 2'd0;
      db_q        <= '0;
      value_q     <= '0;
      digit_cnt_q <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      col_s1_q    <= col;
      col_s2_q    <= col_s1_q;
      btn_s1_q    <= {btn_clear, btn_enter};
      btn_s2_q    <= btn_s1_q;
      btn_prev_q  <= btn_s2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      cand_col_q  <= cand_col_d;
      db_q        <= db_d;
      value_q     <= value_d;
      digit_cnt_q <= digit_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      valid_q     <= valid_d;
    end
  end

  assign row           = ~(4'b0001 << row_idx_q);
  assign bus.value     = value_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.valid     = valid_q;
endmodule

// File: tb/tb_keypad_input.sv
// Directed bench for keypad_input with a behavioural 4x4 keypad model.
module tb_keypad_input;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row, col;
  logic       btn_enter = 1'b0, btn_clear = 1'b0;
  logic       pressed = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  int         n_chk = 0, n_pass = 0, kv_cnt = 0, kv0;

  keypad_if bus ();

  keypad_input #(.SCAN_CYCLES(4), .DB_COUNT(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .bus(bus)
  );

  always #5 clk = ~clk;

  assign col = (pressed && row[key_r] == 1'b0) ? ~(4'b0001 << key_c) : 4'hF;

  always @(posedge clk) if (bus.key_valid === 1'b1) kv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a fresh transition of row to target, bounded.
  task automatic wait_row(input logic [3:0] target, input int budget);
    bit other = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (row != target) other = 1'b1;
      else if (other) break;
      @(negedge clk);
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_r = code[3:2];
    key_c = code[1:0];
    pressed = 1'b1;
    cyc(40);
    pressed = 1'b0;
    cyc(24);
  endtask

  task automatic pulse_btn(input bit is_clear, input bit both);
    if (both) begin btn_enter = 1'b1; btn_clear = 1'b1; end
    else if (is_clear) btn_clear = 1'b1;
    else btn_enter = 1'b1;
    cyc(5);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    cyc(4);
  endtask

  initial begin
    bus.ack = 1'b0;
    // Reset and scan
    cyc(3);
    chk("rst_row", row, 4'b1110);
    chk("rst_value", bus.value, 0);
    chk("rst_cnt", bus.digit_cnt, 0);
    chk("rst_code", bus.key_code, 0);
    chk("rst_kv", bus.key_valid, 0);
    chk("rst_valid", bus.valid, 0);
    rst = 1'b1;
    chk("scan0", row, 4'b1110);
    cyc(4); chk("scan1", row, 4'b1101);
    cyc(4); chk("scan2", row, 4'b1011);
    cyc(4); chk("scan3", row, 4'b0111);
    cyc(4); chk("scan4", row, 4'b1110);

    // Single press row1/col2, no repeat, row resumes at 2
    kv0 = kv_cnt;
    key_r = 2'd1; key_c = 2'd2; pressed = 1'b1;
    cyc(40);
    pressed = 1'b0;
    chk("one_kv", kv_cnt - kv0, 1);
    chk("one_code", bus.key_code, 6);
    chk("one_value", bus.value, 32'h6);
    chk("one_cnt", bus.digit_cnt, 1);
    chk("one_hold_row", row, 4'b1101);
    for (int i = 0; i < 60 && row == 4'b1101; i++) @(negedge clk);
    chk("one_next_row", row, 4'b1011);

    // Bounce: row0/col0 seen low on exactly 2 ticks
    cyc(8);
    kv0 = kv_cnt;
    wait_row(4'b1110, 40);
    key_r = 2'd0; key_c = 2'd0; pressed = 1'b1;
    cyc(8);
    pressed = 1'b0;
    wait_row(4'b1101, 40);
    chk("bnc_row", row, 4'b1101);
    cyc(20);
    chk("bnc_kv", kv_cnt - kv0, 0);
    chk("bnc_value", bus.value, 32'h6);

    // Saturation
    pulse_btn(1'b1, 1'b0);
    chk("clr_value", bus.value, 0);
    chk("clr_cnt", bus.digit_cnt, 0);
    for (int k = 1; k <= 8; k++) press(4'(k));
    chk("sat_value", bus.value, 32'h12345678);
    chk("sat_cnt", bus.digit_cnt, 8);
    kv0 = kv_cnt;
    press(4'd9);
    chk("sat_kv9", kv_cnt - kv0, 0);
    chk("sat_value9", bus.value, 32'h12345678);
    chk("sat_code9", bus.key_code, 8);

    // Commit handshake
    pulse_btn(1'b1, 1'b0);
    press(4'hA);
    press(4'hB);
    pulse_btn(1'b0, 1'b0);
    chk("cm_valid", bus.valid, 1);
    chk("cm_value", bus.value, 32'hAB);
    kv0 = kv_cnt;
    press(4'd3);
    chk("cm_drop_kv", kv_cnt - kv0, 0);
    chk("cm_drop_value", bus.value, 32'hAB);
    chk("cm_drop_code", bus.key_code, 4'hB);
    pulse_btn(1'b1, 1'b0);
    chk("cm_clr_ignored", bus.value, 32'hAB);
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    chk("ack_valid", bus.valid, 0);
    chk("ack_value", bus.value, 0);
    chk("ack_cnt", bus.digit_cnt, 0);
    pulse_btn(1'b0, 1'b0);
    chk("ent_empty", bus.valid, 0);

    // Enter + clear together: clear wins
    press(4'd1);
    chk("pri_pre", bus.digit_cnt, 1);
    pulse_btn(1'b0, 1'b1);
    chk("pri_value", bus.value, 0);
    chk("pri_valid", bus.valid, 0);
    chk("pri_cnt", bus.digit_cnt, 0);

    // Reset during DEBOUNCE
    kv0 = kv_cnt;
    wait_row(4'b1101, 40);
    key_r = 2'd1; key_c = 2'd1; pressed = 1'b1;
    cyc(6);
    rst = 1'b0;
    #1;
    chk("mid_rst_row", row, 4'b1110);
    pressed = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(40);
    chk("mid_rst_kv", kv_cnt - kv0, 0);
    chk("mid_rst_value", bus.value, 0);
    chk("mid_rst_cnt", bus.digit_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
